ifetch_unit: RTL

Instruction fetch unit upstream of the single-cycle core. Owns the fetch PC, issues word-indexed reads to the instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small prefetch FIFO. Supplies the decode/control path over a valid/ready interface. Accepts branch/jump redirects from the branch unit, flushing buffered and in-flight fetches.

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_unit_fifo.sv | 64 ++++++
 rtl/ifetch_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
//   state_t          : fetch FSM states (IDLE, WAIT, DROP)
//   WORD_SHIFT       : byte-address to word-index shift
//   DEFAULT_RESET_PC : default fetch address after reset
//   entry_t          : prefetch entry layout {pc, inst} at the default widths
package ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // no request outstanding
      WAIT = 2'd1,   // request outstanding, returned data is kept
      DROP = 2'd2    // request outstanding, returned data is discarded
   } state_t;

   localparam int          WORD_SHIFT       = 2;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

endpackage

// File: rtl/ifetch_unit_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush.
//   clk, rst : clock and synchronous active-high reset
//   push     : write wdata (ignored when full)
//   pop      : drop head entry (ignored when empty)
//   flush    : empty the FIFO; overrides push and pop
//   wdata    : entry to write
//   rdata    : head entry, zero while empty
//   count    : number of valid entries (0..DEPTH)
module fetch_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_push_s = push && (count_r != DEPTH_C);
   assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
      end
   end

   // Entry storage; contents of empty slots are never observed, so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush && !rst) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   assign rdata = (count_r != {CNT_W{1'b0}}) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
   assign count = count_r;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch unit feeding the decode path.
//   clk, rst              : clock, synchronous active-high reset
//   redirect_valid/_addr  : taken branch/jump and its byte target
//   mem_req/mem_addr      : word-indexed read request to instruction memory
//   mem_ack/mem_rdata     : read data return (only while mem_req=1)
//   inst_valid/inst_ready : valid/ready handshake toward decode
//   inst_data/inst_pc     : head instruction and its byte PC (zero when invalid)
//   misalign_err          : one-cycle pulse after a redirect with low address bits set
// At most one request is outstanding and its FIFO slot is reserved at issue,
// so an acknowledged word always has room to be written.
import ifetch_pkg::*;

module ifetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         redirect_valid,
   input  logic [ADDR_W-1:0]            redirect_addr,
   output logic                         mem_req,
   output logic [ADDR_W-WORD_SHIFT-1:0] mem_addr,
   input  logic                         mem_ack,
   input  logic [DATA_W-1:0]            mem_rdata,
   output logic                         inst_valid,
   input  logic                         inst_ready,
   output logic [DATA_W-1:0]            inst_data,
   output logic [ADDR_W-1:0]            inst_pc,
   output logic                         misalign_err
);

   localparam int                CNT_W   = $clog2(DEPTH) + 1;
   localparam int                WA_W    = ADDR_W - WORD_SHIFT;
   localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1) << WORD_SHIFT;

   state_t              state_r,    state_nx_s;
   logic [ADDR_W-1:0]   fetch_pc_r, fetch_pc_nx_s;
   logic                mem_req_r,  mem_req_nx_s;
   logic [WA_W-1:0]     mem_addr_r, mem_addr_nx_s;
   logic                misalign_r;

   logic [CNT_W-1:0]    count_s;
   logic [CNT_W:0]      post_cnt_s;
   logic                push_s;
   logic                pop_s;
   logic [ADDR_W-1:0]   target_s;
   logic [ADDR_W-1:0]   pc_inc_s;
   logic [ADDR_W+DATA_W-1:0] head_s;

   assign pop_s    = inst_valid && inst_ready;
   assign target_s = {redirect_addr[ADDR_W-1:WORD_SHIFT], {WORD_SHIFT{1'b0}}};
   assign pc_inc_s = fetch_pc_r + PC_STEP;
   // Occupancy after this cycle's push (the ack being considered) and pop.
   assign post_cnt_s = {1'b0, count_s} + (CNT_W + 1)'(1) - (CNT_W + 1)'(pop_s);

   // Next-state, PC and request logic for the fetch FSM.
   always_comb begin
      state_nx_s    = state_r;
      fetch_pc_nx_s = fetch_pc_r;
      mem_req_nx_s  = mem_req_r;
      mem_addr_nx_s = mem_addr_r;
      push_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (redirect_valid) begin
               fetch_pc_nx_s = target_s;
            end else if ({1'b0, count_s} < DEPTH_C) begin
               state_nx_s    = WAIT;
               mem_req_nx_s  = 1'b1;
               mem_addr_nx_s = fetch_pc_r[ADDR_W-1:WORD_SHIFT];
            end else begin
               state_nx_s = IDLE;
            end
         end
         WAIT: begin
            if (mem_ack && redirect_valid) begin
               // Acked word belongs to the old path: drop it and restart from the target.
               state_nx_s    = IDLE;
               mem_req_nx_s  = 1'b0;
               fetch_pc_nx_s = target_s;
            end else if (mem_ack) begin
               push_s        = 1'b1;
               fetch_pc_nx_s = pc_inc_s;
               if (post_cnt_s < DEPTH_C) begin
                  mem_addr_nx_s = pc_inc_s[ADDR_W-1:WORD_SHIFT];
               end else begin
                  state_nx_s   = IDLE;
                  mem_req_nx_s = 1'b0;
               end
            end else if (redirect_valid) begin
               // Request must stay stable until acked; its data will be discarded.
               state_nx_s    = DROP;
               fetch_pc_nx_s = target_s;
            end else begin
               state_nx_s = WAIT;
            end
         end
         DROP: begin
            if (redirect_valid) begin
               fetch_pc_nx_s = target_s;
            end else begin
               fetch_pc_nx_s = fetch_pc_r;
            end
            if (mem_ack) begin
               state_nx_s   = IDLE;
               mem_req_nx_s = 1'b0;
            end else begin
               state_nx_s = DROP;
            end
         end
         default: begin
            state_nx_s   = IDLE;
            mem_req_nx_s = 1'b0;
         end
      endcase
   end

   // State, PC and memory request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         fetch_pc_r <= RESET_PC;
         mem_req_r  <= 1'b0;
         mem_addr_r <= RESET_PC[ADDR_W-1:WORD_SHIFT];
         misalign_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         fetch_pc_r <= fetch_pc_nx_s;
         mem_req_r  <= mem_req_nx_s;
         mem_addr_r <= mem_addr_nx_s;
         misalign_r <= redirect_valid && (redirect_addr[WORD_SHIFT-1:0] != {WORD_SHIFT{1'b0}});
      end
   end

   fetch_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .flush (redirect_valid),
      .wdata ({fetch_pc_r, mem_rdata}),
      .rdata (head_s),
      .count (count_s)
   );

   assign inst_valid   = (count_s != {CNT_W{1'b0}});
   assign inst_pc      = head_s[ADDR_W+DATA_W-1:DATA_W];
   assign inst_data    = head_s[DATA_W-1:0];
   assign mem_req      = mem_req_r;
   assign mem_addr     = mem_addr_r;
   assign misalign_err = misalign_r;

endmodule
